// File: rtl/lc3_control_unit.sv
// LC-3 instruction sequencer: fetch/decode/execute Moore FSM driving all datapath controls.
// Latency: outputs are a pure decode of the current state; memory states hold MEM_WAIT cycles.
// Backpressure: none; PAUSE stalls on Continue handshake. Optional TRAP path: LC3_CU_TRAP_EN.
module lc3_control_unit #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] IR_15_12,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_REG,
    output logic       LD_CC,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic       MARMUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_WE
);

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;
`ifdef LC3_CU_TRAP_EN
    localparam logic [3:0] OP_TRAP  = 4'b1111;
`endif

    // Last cycle index of a memory access state.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        HALTED,
        FETCH1,
        FETCH2,
        FETCH3,
        DECODE,
        EX_ADD,
        EX_AND,
        EX_NOT,
        BR1,
        BR2,
        EX_JMP,
        JSR1,
        JSR2,
        JSRR2,
        ADDR_PC,
        ADDR_REG,
        EX_LEA,
        MEM_RD1,
        MEM_IND,
        MEM_RD2,
        WRITEBACK,
        MDR_SR,
        MEM_WR,
        PAUSE1,
        PAUSE2
`ifdef LC3_CU_TRAP_EN
        ,
        TRAP1,
        TRAP2,
        TRAP3
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_state;
    logic       wait_done;

    // State and wait-counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait counter: counts inside a memory state, zero everywhere else so every entry starts clean.
    always_comb begin
        mem_state = (state_q == FETCH2) || (state_q == MEM_RD1) ||
                    (state_q == MEM_RD2) || (state_q == MEM_WR);
        wait_done = (cnt_q == WAIT_LAST);
        cnt_d     = (mem_state && !wait_done) ? cnt_q + 4'd1 : 4'd0;
    end

    // Next-state and Moore output decode; every output defaults low.
    always_comb begin
        state_d    = state_q;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_REG     = 1'b0;
        LD_CC      = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        PCMUX      = 2'b00;
        DRMUX      = 2'b00;
        SR1MUX     = 2'b00;
        MARMUX     = 1'b0;
        ALUK       = 2'b00;
        MIO_EN     = 1'b0;
        Mem_WE     = 1'b0;

        case (state_q)
            HALTED: begin
                if (Run) state_d = FETCH1;
            end
            FETCH1: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                state_d = FETCH2;
            end
            FETCH2: begin
                MIO_EN = 1'b1;
                LD_MDR = wait_done;
                if (wait_done) state_d = FETCH3;
            end
            FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                LD_BEN = 1'b1;
                case (IR_15_12)
                    OP_ADD:                    state_d = EX_ADD;
                    OP_AND:                    state_d = EX_AND;
                    OP_NOT:                    state_d = EX_NOT;
                    OP_BR:                     state_d = BR1;
                    OP_JMP:                    state_d = EX_JMP;
                    OP_JSR:                    state_d = JSR1;
                    OP_LD, OP_LDI, OP_ST, OP_STI: state_d = ADDR_PC;
                    OP_LDR, OP_STR:            state_d = ADDR_REG;
                    OP_LEA:                    state_d = EX_LEA;
                    OP_PAUSE:                  state_d = PAUSE1;
`ifdef LC3_CU_TRAP_EN
                    OP_TRAP:                   state_d = TRAP1;
`endif
                    default:                   state_d = FETCH1;
                endcase
            end
            EX_ADD, EX_AND, EX_NOT: begin
                SR1MUX  = 2'b01;
                ALUK    = (state_q == EX_ADD) ? 2'b00 : (state_q == EX_AND) ? 2'b01 : 2'b10;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = FETCH1;
            end
            BR1: begin
                state_d = BEN ? BR2 : FETCH1;
            end
            BR2: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = FETCH1;
            end
            EX_JMP: begin
                SR1MUX  = 2'b01;
                ALUK    = 2'b11;
                GateALU = 1'b1;
                PCMUX   = 2'b01;
                LD_PC   = 1'b1;
                state_d = FETCH1;
            end
            // R7 captures the return PC before the target is computed.
            JSR1: begin
                GatePC  = 1'b1;
                DRMUX   = 2'b01;
                LD_REG  = 1'b1;
                state_d = IR_11 ? JSR2 : JSRR2;
            end
            JSR2: begin
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = FETCH1;
            end
            JSRR2: begin
                SR1MUX   = 2'b01;
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = FETCH1;
            end
            ADDR_PC, ADDR_REG: begin
                if (state_q == ADDR_REG) begin
                    SR1MUX   = 2'b01;
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = 2'b01;
                end else begin
                    ADDR2MUX = 2'b10;
                end
                MARMUX     = 1'b1;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                // Direct stores skip the read; STI needs its pointer fetched first.
                state_d = (IR_15_12 == OP_ST || IR_15_12 == OP_STR) ? MDR_SR : MEM_RD1;
            end
            EX_LEA: begin
                ADDR2MUX   = 2'b10;
                MARMUX     = 1'b1;
                GateMARMUX = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_d    = FETCH1;
            end
            MEM_RD1: begin
                MIO_EN = 1'b1;
                LD_MDR = wait_done;
                if (wait_done) begin
                    if (IR_15_12 == OP_LDI || IR_15_12 == OP_STI) state_d = MEM_IND;
`ifdef LC3_CU_TRAP_EN
                    else if (IR_15_12 == OP_TRAP)                 state_d = TRAP3;
`endif
                    else                                          state_d = WRITEBACK;
                end
            end
            MEM_IND: begin
                GateMDR = 1'b1;
                LD_MAR  = 1'b1;
                state_d = (IR_15_12 == OP_STI) ? MDR_SR : MEM_RD2;
            end
            MEM_RD2: begin
                MIO_EN = 1'b1;
                LD_MDR = wait_done;
                if (wait_done) state_d = WRITEBACK;
            end
            WRITEBACK: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = FETCH1;
            end
            // Store data passes through the ALU; MIO_EN stays low so MDR takes the bus.
            MDR_SR: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = MEM_WR;
            end
            MEM_WR: begin
                Mem_WE = 1'b1;
                if (wait_done) state_d = FETCH1;
            end
            PAUSE1: begin
                if (Continue) state_d = PAUSE2;
            end
            PAUSE2: begin
                if (!Continue) state_d = FETCH1;
            end
`ifdef LC3_CU_TRAP_EN
            TRAP1: begin
                GatePC  = 1'b1;
                DRMUX   = 2'b01;
                LD_REG  = 1'b1;
                state_d = TRAP2;
            end
            TRAP2: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = MEM_RD1;
            end
            TRAP3: begin
                GateMDR = 1'b1;
                PCMUX   = 2'b01;
                LD_PC   = 1'b1;
                state_d = FETCH1;
            end
`endif
            default: state_d = HALTED;
        endcase
    end

endmodule
